fsm16_stim_driver: RTL and testbench
====================================

// Module: fsm16_stim_driver
// PURPOSE
//  Transmit side for the 16-state dual-input branching FSM. Converts a stream of 1-bit branch
//  decisions (1 = condition-true successor, 0 = condition-false successor) into input1/input2
//  pairs that steer that FSM. Keeps a golden mirror of the FSM state and optionally checks the
//  observed state against it. Used in bring-up benches and BIST harnesses.
// PARAMETERS
//  DEPTH        4   command FIFO entries (power of 2, >=2)
//  IDLE_BRANCH  0   branch value used when run=1 and the FIFO is empty
// PORTS
//  clk        in   1  clock
//  reset      in   1  synchronous, active-high
//  cmd_valid  in   1  branch command offered
//  cmd_branch in   1  branch decision
//  cmd_ready  out  1  FIFO can accept (= !full)
//  run        in   1  advance enable for this cycle
//  step       out  1  = run & !reset; harness uses it as the FSM clock enable
//  input1     out  1  steering input a (combinational from mirror state and FIFO head)
//  input2     out  1  steering input b
//  mirror     out  4  golden FSM state
//  underrun   out  1  1-cycle pulse: step taken with empty FIFO
//  obs_state  in   4  DUT state (used only with the checker)
//  mismatch   out  1  sticky; checker only
//  mm_exp     out  4  expected state at the first mismatch
//  mm_obs     out  4  observed state at the first mismatch
// BEHAVIOUR
//  - Reset: mirror=0, FIFO empty, underrun=0, mismatch=0, mm_exp=mm_obs=0; input1/input2 forced 0.
//  - Successors with k = mirror[2:0]: taken = (2k+1) mod 16, not-taken = (2k+2) mod 16.
//    Gives S7 and S15: taken->15, not-taken->0.
//  - Canonical (input1,input2) per k, as true/false pair:
//      0 a&b  (1,1)/(0,0)    1 !a&b (0,1)/(1,1)    2 a&!b (1,0)/(1,1)    3 !a&!b (0,0)/(1,1)
//      4 a|b  (1,1)/(0,0)    5 !a|b (0,1)/(1,0)    6 a|!b (1,0)/(0,1)    7 !a|!b (0,0)/(1,1)
//  - br = FIFO head when non-empty, else IDLE_BRANCH.
//  - Outputs are driven from (mirror, br) every cycle, even when step=0.
//  - On step: mirror <= successor(mirror, br); pop the head if non-empty, else pulse underrun.
//  - On step=0: mirror holds, no pop, underrun=0.
//  - Push on cmd_valid & cmd_ready. No bypass: a push into an empty FIFO is consumed next step at
//    the earliest.
//  - Push and pop in the same cycle: count is unchanged, order is preserved.
//  - cmd_ready is taken from the registered count, so a full FIFO refuses a push even in a cycle
//    that pops.
//  - Pointers wrap mod DEPTH. Count width is clog2(DEPTH)+1.
//  - Reset mid-stream drops all queued commands and returns mirror to S0.
// CONFIGURATION
//  FSM16_DRV_CHECK_EN defined:
//   - Each cycle with a step in the previous cycle, compare obs_state against mirror.
//   - On the first difference: set mismatch, capture mm_exp/mm_obs. Later differences do not
//     overwrite. Cleared only by reset.
//  FSM16_DRV_CHECK_EN undefined:
//   - No checker logic; mismatch, mm_exp and mm_obs are tied to 0; obs_state is ignored.
// STRUCTURE
//  - Package fsm16_pkg: state_t (4-bit), S0..S15 constants, function next_state(s, br),
//    function drive_pair(s, br) returning {input1,input2}.
//  - Sub-module fsm16_cmd_fifo (DEPTH x 1-bit, registered count, full/empty flags).
//  - Top holds the mirror register, output mux and checker.
// TESTING
//  1. Reset, run=1, push 1,1,1 -> pairs (1,1),(0,1),(0,0); mirror 1,3,7.
//  2. From S7, push 0 -> pair (1,1), mirror 0. With the checker on and obs_state=1 -> mismatch=1,
//     mm_exp=0, mm_obs=1.
//  3. From S0, run=1, FIFO empty -> pair (0,0), mirror 2, underrun pulses one cycle.
//  4. run=0, push 4 -> cmd_ready=0 after the 4th push. Then run=1: ready returns the next cycle
//     and the order is preserved.
//  5. Mirror S14 with br=0 -> (0,1) repeatedly, mirror stays 14. Mirror S15 with br=1 -> (0,0),
//     mirror stays 15.
//  6. Reset asserted with 3 entries queued -> FIFO empty, mirror 0, input1=input2=0 during reset.

Source files
------------

// File: rtl/fsm16_pkg.sv
// Shared types and helpers for the 16-state dual-input branching FSM stimulus driver.
// Provides the state type, successor rule and canonical steering pair per state.
package fsm16_pkg;

  typedef enum logic [3:0] {
    S0,  S1,  S2,  S3,  S4,  S5,  S6,  S7,
    S8,  S9,  S10, S11, S12, S13, S14, S15
  } state_t;

  // Only the low three bits select the branch condition; the successor doubles them.
  function automatic state_t next_state(input state_t s, input logic br);
    logic [3:0] n;
    n = {s[2:0], 1'b0} + (br ? 4'd1 : 4'd2);
    return state_t'(n);
  endfunction

  // Returns {input1, input2} making the state's condition evaluate to br.
  function automatic logic [1:0] drive_pair(input state_t s, input logic br);
    logic [1:0] p;
    case (s[2:0])
      3'd0:    p = br ? 2'b11 : 2'b00;  // a & b
      3'd1:    p = br ? 2'b01 : 2'b11;  // !a & b
      3'd2:    p = br ? 2'b10 : 2'b11;  // a & !b
      3'd3:    p = br ? 2'b00 : 2'b11;  // !a & !b
      3'd4:    p = br ? 2'b11 : 2'b00;  // a | b
      3'd5:    p = br ? 2'b01 : 2'b10;  // !a | b
      3'd6:    p = br ? 2'b10 : 2'b01;  // a | !b
      default: p = br ? 2'b00 : 2'b11;  // !a | !b
    endcase
    return p;
  endfunction

endpackage

// File: rtl/fsm16_cmd_fifo.sv
// DEPTH x 1-bit branch command FIFO with registered occupancy count.
// Storage is not reset; only pointers and count are.
module fsm16_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fsm16_stim_driver.sv
// Converts queued branch decisions into input1/input2 pairs for the 16-state FSM and
// keeps a golden mirror of its state. Optional checker enabled by FSM16_DRV_CHECK_EN.
module fsm16_stim_driver
  import fsm16_pkg::*;
#(
  parameter int   DEPTH       = 4,
  parameter logic IDLE_BRANCH = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_branch,
  output logic       cmd_ready,
  input  logic       run,
  output logic       step,
  output logic       input1,
  output logic       input2,
  output logic [3:0] mirror,
  output logic       underrun,
  input  logic [3:0] obs_state,
  output logic       mismatch,
  output logic [3:0] mm_exp,
  output logic [3:0] mm_obs
);

  state_t mirror_q;
  logic   head;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   br;

  assign step      = run & ~reset;
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = step & ~empty;
  assign br        = empty ? IDLE_BRANCH : head;

  fsm16_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (cmd_branch),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mirror_q <= S0;
      underrun <= 1'b0;
    end else begin
      if (step) mirror_q <= next_state(mirror_q, br);
      underrun <= step & empty;
    end
  end

  assign mirror           = mirror_q;
  assign {input1, input2} = reset ? 2'b00 : drive_pair(mirror_q, br);

`ifdef FSM16_DRV_CHECK_EN
  // The observed FSM advances on the same edge as the mirror, so compare one cycle after a step.
  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= 1'b0;
      mismatch <= 1'b0;
      mm_exp   <= 4'd0;
      mm_obs   <= 4'd0;
    end else begin
      step_q <= step;
      if (step_q && !mismatch && (obs_state != mirror_q)) begin
        mismatch <= 1'b1;
        mm_exp   <= mirror_q;
        mm_obs   <= obs_state;
      end
    end
  end
`else
  logic unused_obs;
  assign unused_obs = ^obs_state;
  assign mismatch   = 1'b0;
  assign mm_exp     = 4'd0;
  assign mm_obs     = 4'd0;
`endif

endmodule

// File: tb/tb_fsm16_stim_driver.sv
// Directed plus randomized bench for fsm16_stim_driver against a queue-based reference model.
module tb_fsm16_stim_driver;

  localparam int DEPTH       = 4;
  localparam bit IDLE_BRANCH = 1'b0;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_branch;
  logic       cmd_ready;
  logic       run;
  logic       step;
  logic       input1;
  logic       input2;
  logic [3:0] mirror;
  logic       underrun;
  logic [3:0] obs_state;
  logic       mismatch;
  logic [3:0] mm_exp;
  logic [3:0] mm_obs;

  fsm16_stim_driver #(
    .DEPTH       (DEPTH),
    .IDLE_BRANCH (IDLE_BRANCH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_branch (cmd_branch),
    .cmd_ready  (cmd_ready),
    .run        (run),
    .step       (step),
    .input1     (input1),
    .input2     (input2),
    .mirror     (mirror),
    .underrun   (underrun),
    .obs_state  (obs_state),
    .mismatch   (mismatch),
    .mm_exp     (mm_exp),
    .mm_obs     (mm_obs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queued commands, mirrored state, registered flags.
  bit q[$];
  int m_mirror;
  bit m_underrun;
  bit m_step_prev;
  bit m_mm;
  int m_mm_exp;
  int m_mm_obs;

  // Canonical {input1,input2} encoded as 2*a+b, indexed by k = state mod 8.
  int tpair[8] = '{3, 1, 2, 0, 3, 1, 2, 0};
  int fpair[8] = '{0, 3, 3, 3, 0, 2, 1, 3};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mirror    = 0;
    m_underrun  = 0;
    m_step_prev = 0;
    m_mm        = 0;
    m_mm_exp    = 0;
    m_mm_obs    = 0;
  endtask

  // One clock cycle: drive at negedge, check, then advance the model for the coming posedge.
  task automatic tick(input bit rst, input bit v, input bit b, input bit r, input logic [3:0] obs);
    bit br;
    bit rdy;
    bit stp;
    int pair;
    @(negedge clk);
    reset      = rst;
    cmd_valid  = v;
    cmd_branch = b;
    run        = r;
    obs_state  = obs;
    #1;
    br   = (q.size() > 0) ? q[0] : IDLE_BRANCH;
    rdy  = (q.size() < DEPTH);
    stp  = r && !rst;
    pair = rst ? 0 : (br ? tpair[m_mirror % 8] : fpair[m_mirror % 8]);
    chk("cmd_ready", {3'b0, cmd_ready}, 4'(rdy));
    chk("step", {3'b0, step}, 4'(stp));
    chk("pair", {2'b0, input1, input2}, 4'(pair));
    chk("mirror", mirror, 4'(m_mirror));
    chk("underrun", {3'b0, underrun}, 4'(m_underrun));
`ifdef FSM16_DRV_CHECK_EN
    chk("mismatch", {3'b0, mismatch}, 4'(m_mm));
    chk("mm_exp", mm_exp, 4'(m_mm_exp));
    chk("mm_obs", mm_obs, 4'(m_mm_obs));
`else
    chk("mismatch", {3'b0, mismatch}, 4'd0);
    chk("mm_exp", mm_exp, 4'd0);
    chk("mm_obs", mm_obs, 4'd0);
`endif
    if (rst) begin
      model_reset();
    end else begin
      if (m_step_prev && !m_mm && (int'(obs) != m_mirror)) begin
        m_mm     = 1;
        m_mm_exp = m_mirror;
        m_mm_obs = int'(obs);
      end
      m_step_prev = stp;
      m_underrun  = 0;
      if (stp) begin
        m_mirror = (2 * (m_mirror % 8) + (br ? 1 : 2)) % 16;
        if (q.size() > 0) void'(q.pop_front());
        else m_underrun = 1;
      end
      if (v && rdy) q.push_back(b);
    end
  endtask

  function automatic logic [3:0] cur();
    return 4'(m_mirror);
  endfunction

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_branch = 1'b0;
    run        = 1'b0;
    obs_state  = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state
    tick(1, 0, 0, 1, 0);
    // Test 1: queue 1,1,1 then run -> S1, S3, S7
    tick(0, 1, 1, 0, cur());
    tick(0, 1, 1, 0, cur());
    tick(0, 1, 1, 0, cur());
    repeat (3) tick(0, 0, 0, 1, cur());
    // Test 2: from S7 branch 0 -> S0; then report a wrong observed state
    tick(0, 1, 0, 0, cur());
    tick(0, 0, 0, 1, cur());
    tick(0, 0, 0, 0, 4'd1);
    tick(0, 0, 0, 0, cur());
    // Test 3: empty FIFO while running -> idle branch, underrun pulse
    tick(0, 0, 0, 1, cur());
    tick(0, 0, 0, 0, cur());
    tick(0, 0, 0, 0, cur());
    // Test 4: fill, refuse at full (even while popping), drain in order
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 1, 0, cur());
    tick(0, 1, 0, 0, cur());
    tick(0, 1, 0, 0, cur());
    tick(0, 1, 1, 0, cur());
    tick(0, 1, 1, 0, cur());
    tick(0, 1, 1, 1, cur());
    repeat (4) tick(0, 0, 0, 1, cur());
    // Test 5: idle branch 0 walks S0->S2->S6->S14 and holds at S14
    tick(1, 0, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 1, cur());
    // Taken branches to S15 and holding there
    tick(1, 0, 0, 0, 0);
    repeat (4) tick(0, 1, 1, 0, cur());
    repeat (8) tick(0, 1, 1, 1, cur());
    // Test 6: reset with entries queued
    tick(1, 0, 0, 0, 0);
    repeat (3) tick(0, 1, 1, 0, cur());
    tick(1, 1, 0, 1, cur());
    tick(0, 0, 0, 1, cur());
    tick(0, 0, 0, 0, cur());

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] o;
      o = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : cur();
      tick(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom), o);
    end
    tick(0, 0, 0, 0, cur());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
